multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control_pkg.sv | 38 +++
 rtl/multicycle_control_if.sv | 40 ++++
 rtl/multicycle_control_alu_decoder.sv | 59 +++++
 rtl/multicycle_control.sv | 138 +++++++++++++
 tb/tb_multicycle_control.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/multicycle_control_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_pkg
// Description : Shared definitions for the multicycle controller: ALU
//               operation codes, RV32 opcode values and the FSM state enum.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package multicycle_control_pkg;

   // ALU operation codes
   localparam logic [3:0] c_ALU_AND = 4'b0000;
   localparam logic [3:0] c_ALU_OR  = 4'b0001;
   localparam logic [3:0] c_ALU_ADD = 4'b0010;
   localparam logic [3:0] c_ALU_SUB = 4'b0110;
   localparam logic [3:0] c_ALU_SLT = 4'b0100;
   localparam logic [3:0] c_ALU_XOR = 4'b0101;
   localparam logic [3:0] c_ALU_SRL = 4'b1000;
   localparam logic [3:0] c_ALU_SLL = 4'b1001;
   localparam logic [3:0] c_ALU_SRA = 4'b1010;

   // Supported opcodes
   localparam logic [6:0] c_OP_RTYPE = 7'b0110011;
   localparam logic [6:0] c_OP_IALU  = 7'b0010011;
   localparam logic [6:0] c_OP_LW    = 7'b0000011;
   localparam logic [6:0] c_OP_SW    = 7'b0100011;
   localparam logic [6:0] c_OP_BEQ   = 7'b1100011;

   typedef enum logic [2:0] {
      S_IF  = 3'd0,
      S_ID  = 3'd1,
      S_EX  = 3'd2,
      S_MEM = 3'd3,
      S_WB  = 3'd4
   } state_t;

endpackage
`default_nettype wire

// File: rtl/multicycle_control_if.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_if
// Description : Bundle between the multicycle controller and its datapath.
// Signals     : instr, zero, mem_ready      - datapath -> controller
//               alu_op, alu_src, mem_read, mem_write, mem_to_reg,
//               reg_write, load_pc, pc_src, state, illegal
//                                           - controller -> datapath
// Modports    : slave  - the controller side
//               master - the datapath side
// Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_control_if;
   logic [31:0] instr;
   logic        zero;
   logic        mem_ready;
   logic [3:0]  alu_op;
   logic        alu_src;
   logic        mem_read;
   logic        mem_write;
   logic        mem_to_reg;
   logic        reg_write;
   logic        load_pc;
   logic        pc_src;
   logic [2:0]  state;
   logic        illegal;

   modport slave (
      input  instr, zero, mem_ready,
      output alu_op, alu_src, mem_read, mem_write, mem_to_reg,
             reg_write, load_pc, pc_src, state, illegal
   );

   modport master (
      output instr, zero, mem_ready,
      input  alu_op, alu_src, mem_read, mem_write, mem_to_reg,
             reg_write, load_pc, pc_src, state, illegal
   );
endinterface
`default_nettype wire

// File: rtl/multicycle_control_alu_decoder.sv
`default_nettype none
// ============================================================================
// Module      : alu_decoder
// Description : Combinational opcode/funct decode to ALU operation, operand
//               select and legality.
// Ports       : i_opcode   [6:0] instruction opcode
//               i_funct3   [2:0] funct3 field
//               i_funct7_5       bit 30 of the instruction (funct7[5])
//               o_alu_op   [3:0] ALU operation
//               o_alu_src        1 = immediate operand
//               o_legal          instruction is supported
// Revision    : 1.0 - initial release
// ============================================================================
module alu_decoder
   import multicycle_control_pkg::*;
(
   input  logic [6:0] i_opcode,
   input  logic [2:0] i_funct3,
   input  logic       i_funct7_5,
   output logic [3:0] o_alu_op,
   output logic       o_alu_src,
   output logic       o_legal
);

   always_comb begin
      o_alu_op  = c_ALU_AND;
      o_alu_src = 1'b0;
      o_legal   = 1'b0;
      case (i_opcode)
         c_OP_RTYPE, c_OP_IALU: begin
            o_legal   = 1'b1;
            o_alu_src = (i_opcode == c_OP_IALU);
            case (i_funct3)
               // bit 30 is part of the immediate for ADDI, so SUB is R-type only
               3'b000:  o_alu_op = (i_opcode == c_OP_RTYPE && i_funct7_5) ? c_ALU_SUB : c_ALU_ADD;
               3'b001:  o_alu_op = c_ALU_SLL;
               3'b010:  o_alu_op = c_ALU_SLT;
               3'b100:  o_alu_op = c_ALU_XOR;
               3'b101:  o_alu_op = i_funct7_5 ? c_ALU_SRA : c_ALU_SRL;
               3'b110:  o_alu_op = c_ALU_OR;
               3'b111:  o_alu_op = c_ALU_AND;
               default: o_legal  = 1'b0;
            endcase
         end
         c_OP_LW, c_OP_SW: begin
            o_legal   = 1'b1;
            o_alu_op  = c_ALU_ADD;
            o_alu_src = 1'b1;
         end
         c_OP_BEQ: begin
            o_legal   = 1'b1;
            o_alu_op  = c_ALU_SUB;
         end
         default: o_legal = 1'b0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control
// Description : Five-state (IF/ID/EX/MEM/WB) controller for a multicycle
//               RV32 subset datapath (R-type, I-ALU, LW, SW, BEQ).
// Ports       : clk  - clock, rising edge
//               rst  - synchronous reset, active low
//               bus  - controller side of multicycle_control_if
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control
   import multicycle_control_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   multicycle_control_if.slave    bus
);

   state_t      r_state;
   state_t      w_next;
   logic [31:0] r_instr;

   logic [3:0]  w_dec_op;
   logic        w_dec_src;
   logic        w_legal;
   logic        w_is_lw;
   logic        w_is_sw;
   logic        w_is_beq;

   logic [3:0]  w_alu_op;
   logic        w_alu_src;
   logic        w_mem_read;
   logic        w_mem_write;
   logic        w_mem_to_reg;
   logic        w_reg_write;
   logic        w_load_pc;
   logic        w_pc_src;
   logic        w_illegal;

   // Register-number and immediate fields belong to the datapath
   logic        w_unused;
   assign w_unused = ^{r_instr[31], r_instr[29:15], r_instr[11:7]};

   alu_decoder u_alu_decoder (
      .i_opcode   (r_instr[6:0]),
      .i_funct3   (r_instr[14:12]),
      .i_funct7_5 (r_instr[30]),
      .o_alu_op   (w_dec_op),
      .o_alu_src  (w_dec_src),
      .o_legal    (w_legal)
   );

   assign w_is_lw  = (r_instr[6:0] == c_OP_LW);
   assign w_is_sw  = (r_instr[6:0] == c_OP_SW);
   assign w_is_beq = (r_instr[6:0] == c_OP_BEQ);

   // Instruction is captured only when leaving IF; later bus changes are ignored
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= S_IF;
         r_instr <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == S_IF)
            r_instr <= bus.instr;
      end
   end

   always_comb begin
      w_next       = S_IF;
      w_alu_op     = '0;
      w_alu_src    = 1'b0;
      w_mem_read   = 1'b0;
      w_mem_write  = 1'b0;
      w_mem_to_reg = 1'b0;
      w_reg_write  = 1'b0;
      w_load_pc    = 1'b0;
      w_pc_src     = 1'b0;
      w_illegal    = 1'b0;
      case (r_state)
         S_IF: w_next = S_ID;
         S_ID: begin
            if (w_legal) begin
               w_next = S_EX;
            end else begin
               // Unsupported instruction retires here and returns to fetch
               w_illegal = 1'b1;
               w_load_pc = 1'b1;
            end
         end
         S_EX: begin
            w_alu_op  = w_dec_op;
            w_alu_src = w_dec_src;
            if (w_is_lw || w_is_sw) begin
               w_next = S_MEM;
            end else if (w_is_beq) begin
               w_load_pc = 1'b1;
               w_pc_src  = bus.zero;
            end else begin
               w_next = S_WB;
            end
         end
         S_MEM: begin
            w_alu_op    = w_dec_op;
            w_alu_src   = w_dec_src;
            w_mem_read  = w_is_lw;
            w_mem_write = w_is_sw;
            if (!bus.mem_ready)
               w_next = S_MEM;
            else if (w_is_lw)
               w_next = S_WB;
            else
               w_load_pc = 1'b1;
         end
         S_WB: begin
            w_alu_op     = w_dec_op;
            w_alu_src    = w_dec_src;
            w_reg_write  = 1'b1;
            w_mem_to_reg = w_is_lw;
            w_load_pc    = 1'b1;
         end
         default: w_next = S_IF;
      endcase
   end

   assign bus.state      = r_state;
   assign bus.alu_op     = w_alu_op;
   assign bus.alu_src    = w_alu_src;
   assign bus.mem_read   = w_mem_read;
   assign bus.mem_write  = w_mem_write;
   assign bus.mem_to_reg = w_mem_to_reg;
   assign bus.reg_write  = w_reg_write;
   assign bus.load_pc    = w_load_pc;
   assign bus.pc_src     = w_pc_src;
   assign bus.illegal    = w_illegal;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control
// Description : Self-checking bench for multicycle_control. A table of
//               instructions with hand-computed ALU settings is replayed
//               cycle by cycle; reset corner cases are hand-written.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

   typedef enum int {K_ALU, K_LW, K_SW, K_BEQ, K_ILL} kind_t;

   typedef struct {
      logic [31:0] instr;
      kind_t       kind;
      logic        zero;
      int          n_wait;
      logic [3:0]  op;
      logic        src;
   } vec_t;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;
   vec_t vecs[$];

   multicycle_control_if bus ();

   multicycle_control dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input int idx, input int cyc,
                      input logic [3:0] act, input logic [3:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s vec%0d cyc%0d: got %0h required %0h", nm, idx, cyc, act, exp);
      end
   endtask

   task automatic chk_idle(input string tag, input int idx);
      chk({tag, "_state"},     idx, 0, {1'b0, bus.state}, 4'd0);
      chk({tag, "_alu_op"},    idx, 0, bus.alu_op, 4'd0);
      chk({tag, "_alu_src"},   idx, 0, {3'b0, bus.alu_src}, 4'd0);
      chk({tag, "_mem_read"},  idx, 0, {3'b0, bus.mem_read}, 4'd0);
      chk({tag, "_mem_write"}, idx, 0, {3'b0, bus.mem_write}, 4'd0);
      chk({tag, "_mem_to_reg"},idx, 0, {3'b0, bus.mem_to_reg}, 4'd0);
      chk({tag, "_reg_write"}, idx, 0, {3'b0, bus.reg_write}, 4'd0);
      chk({tag, "_load_pc"},   idx, 0, {3'b0, bus.load_pc}, 4'd0);
      chk({tag, "_pc_src"},    idx, 0, {3'b0, bus.pc_src}, 4'd0);
      chk({tag, "_illegal"},   idx, 0, {3'b0, bus.illegal}, 4'd0);
   endtask

   // Entry: just after a rising edge with the controller in IF.
   // Exit: just after the rising edge that ends the instruction.
   task automatic run_vec(input vec_t v, input int idx);
      logic [2:0] seq[$];
      int         memc;
      logic [2:0] st;
      logic       last;
      seq.push_back(3'd0);
      seq.push_back(3'd1);
      if (v.kind != K_ILL) seq.push_back(3'd2);
      if (v.kind == K_LW || v.kind == K_SW)
         for (int k = 0; k <= v.n_wait; k++) seq.push_back(3'd3);
      if (v.kind == K_ALU || v.kind == K_LW) seq.push_back(3'd4);
      memc = 0;
      for (int c = 0; c < seq.size(); c++) begin
         st   = seq[c];
         last = (c == seq.size() - 1);
         // After IF the bus carries an illegal opcode that must be ignored
         bus.instr     = (c == 0) ? v.instr : 32'hFFFF_FFFF;
         bus.zero      = v.zero;
         bus.mem_ready = (st == 3'd3) ? (memc == v.n_wait) : 1'b1;
         @(negedge clk);
         chk("state",      idx, c, {1'b0, bus.state}, {1'b0, st});
         chk("alu_op",     idx, c, bus.alu_op, (st >= 3'd2) ? v.op : 4'd0);
         chk("alu_src",    idx, c, {3'b0, bus.alu_src}, {3'b0, (st >= 3'd2) ? v.src : 1'b0});
         chk("mem_read",   idx, c, {3'b0, bus.mem_read}, {3'b0, (v.kind == K_LW && st == 3'd3)});
         chk("mem_write",  idx, c, {3'b0, bus.mem_write}, {3'b0, (v.kind == K_SW && st == 3'd3)});
         chk("mem_to_reg", idx, c, {3'b0, bus.mem_to_reg}, {3'b0, (v.kind == K_LW && st == 3'd4)});
         chk("reg_write",  idx, c, {3'b0, bus.reg_write}, {3'b0, (st == 3'd4)});
         chk("load_pc",    idx, c, {3'b0, bus.load_pc}, {3'b0, last});
         chk("pc_src",     idx, c, {3'b0, bus.pc_src}, {3'b0, (v.kind == K_BEQ && st == 3'd2) ? v.zero : 1'b0});
         chk("illegal",    idx, c, {3'b0, bus.illegal}, {3'b0, (v.kind == K_ILL && st == 3'd1)});
         if (st == 3'd3) memc++;
         @(posedge clk);
         #1;
      end
      chk("next_if", idx, seq.size(), {1'b0, bus.state}, 4'd0);
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;

      //                instr          kind   zero  wait  op       src
      vecs.push_back('{32'h002081B3, K_ALU, 1'b0, 0, 4'b0010, 1'b0}); // ADD
      vecs.push_back('{32'h402081B3, K_ALU, 1'b1, 0, 4'b0110, 1'b0}); // SUB
      vecs.push_back('{32'h4020D1B3, K_ALU, 1'b0, 0, 4'b1010, 1'b0}); // SRA
      vecs.push_back('{32'h0020D1B3, K_ALU, 1'b0, 0, 4'b1000, 1'b0}); // SRL
      vecs.push_back('{32'h002091B3, K_ALU, 1'b0, 0, 4'b1001, 1'b0}); // SLL
      vecs.push_back('{32'h0020A1B3, K_ALU, 1'b0, 0, 4'b0100, 1'b0}); // SLT
      vecs.push_back('{32'h0020C1B3, K_ALU, 1'b0, 0, 4'b0101, 1'b0}); // XOR
      vecs.push_back('{32'h0020E1B3, K_ALU, 1'b0, 0, 4'b0001, 1'b0}); // OR
      vecs.push_back('{32'h0020F1B3, K_ALU, 1'b0, 0, 4'b0000, 1'b0}); // AND
      vecs.push_back('{32'h00508193, K_ALU, 1'b0, 0, 4'b0010, 1'b1}); // ADDI 5
      vecs.push_back('{32'h40008193, K_ALU, 1'b0, 0, 4'b0010, 1'b1}); // ADDI 1024 (bit30 set)
      vecs.push_back('{32'h4030D193, K_ALU, 1'b0, 0, 4'b1010, 1'b1}); // SRAI 3
      vecs.push_back('{32'h0080A183, K_LW,  1'b0, 2, 4'b0010, 1'b1}); // LW, 2 waits
      vecs.push_back('{32'h0080A183, K_LW,  1'b1, 0, 4'b0010, 1'b1}); // LW, no wait
      vecs.push_back('{32'h0020A423, K_SW,  1'b0, 1, 4'b0010, 1'b1}); // SW, 1 wait
      vecs.push_back('{32'h0020A423, K_SW,  1'b0, 0, 4'b0010, 1'b1}); // SW, no wait
      vecs.push_back('{32'h00208063, K_BEQ, 1'b1, 0, 4'b0110, 1'b0}); // BEQ taken
      vecs.push_back('{32'h00208063, K_BEQ, 1'b0, 0, 4'b0110, 1'b0}); // BEQ not taken
      vecs.push_back('{32'h0000007F, K_ILL, 1'b0, 0, 4'b0000, 1'b0}); // opcode 1111111
      vecs.push_back('{32'h0020B1B3, K_ILL, 1'b0, 0, 4'b0000, 1'b0}); // R-type funct3 011
      vecs.push_back('{32'h0000B193, K_ILL, 1'b0, 0, 4'b0000, 1'b0}); // I-ALU funct3 011

      // Reset held over two edges; outputs must be idle while still in reset
      rst           = 1'b0;
      bus.instr     = 32'h002081B3;
      bus.zero      = 1'b1;
      bus.mem_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      chk_idle("reset", -1);
      @(posedge clk);
      #1;
      rst = 1'b1;

      foreach (vecs[i]) run_vec(vecs[i], i);

      // Reset in the middle of a SW memory wait
      bus.instr     = 32'h0020A423;
      bus.mem_ready = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
         bus.instr = 32'hFFFF_FFFF;
      end
      @(negedge clk);
      chk("swrst_state_mem", 100, 3, {1'b0, bus.state}, 4'd3);
      chk("swrst_mem_write", 100, 3, {3'b0, bus.mem_write}, 4'd1);
      chk("swrst_load_pc",   100, 3, {3'b0, bus.load_pc}, 4'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      chk_idle("post_reset", 100);
      @(posedge clk);
      #1;
      chk("post_reset_id", 100, 5, {1'b0, bus.state}, 4'd1);
      // Let the stray fetch drain (it is the illegal pattern on the bus)
      @(negedge clk);
      chk("post_reset_ill",  100, 5, {3'b0, bus.illegal}, 4'd1);
      chk("post_reset_wr",   100, 5, {3'b0, bus.mem_write}, 4'd0);
      @(posedge clk);
      #1;
      run_vec(vecs[0], 101);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
